mems_marker_fifo_writer: RTL and testbench
==========================================

Name: mems_marker_fifo_writer

Overview:
Consumes the sticky new_line / new_frame request flags from the fake MEMS scan generator. Acknowledges each flag with a one-cycle *_FIFO_done pulse. Interleaves tagged line/frame marker words with the measurement sample stream into the 32-bit output FIFO write port, so the readout side can reconstruct scan geometry. Sits between the MEMS timing source plus sample front-end and the output FIFO.

Parameters:
DATA_W, 16, sample width (must be 16 for the packing below)
IDX_W, 14, sample-index-within-line field width
CNT_W, 16, line counter width

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
new_line  input  1  sticky line request; held high until new_line_FIFO_done is seen
new_frame  input  1  sticky frame request; held high until new_frame_FIFO_done is seen
sample_valid  input  1  one-cycle strobe, sample_data valid
sample_data  input  DATA_W  measurement sample
fifo_full  input  1  output FIFO full
fifo_wr_en  output  1  FIFO write strobe
fifo_din  output  32  FIFO write word
new_line_FIFO_done  output  1  one-cycle ack of new_line
new_frame_FIFO_done  output  1  one-cycle ack of new_frame
line_cnt  output  CNT_W  lines since last frame marker
frame_cnt  output  30  frames since reset
drop_cnt  output  16  samples lost, saturating

Behaviour:
- Reset is asynchronous, active-low. While rst_n=0, every output, counter, and the hold register are 0, and state is IDLE.
- Reset mid-operation abandons any pending marker without a done pulse. The upstream flag stays high and is serviced normally after reset.
- All outputs are registered. fifo_wr_en=1 for exactly one cycle per word, and never while fifo_full=1 was sampled.
- Word format is [31:30] tag:
  - Data: tag 00, [29:16] sample index, [15:0] sample.
  - Line marker: tag 01, [29:16] frame_cnt[13:0], [15:0] line_cnt value after increment.
  - Frame marker: tag 10, [29:0] frame_cnt value after increment.
- The hold register is 1-deep, with a valid bit, for samples that cannot be written immediately.
- FSM state IDLE. Priority when !fifo_full:
  1. hold valid: write hold.
  2. new_frame: go to FRAME_MARK.
  3. new_line: go to LINE_MARK.
  4. sample_valid: write sample directly.
- In IDLE with fifo_full=1, no write occurs and the state is unchanged.
- FSM state LINE_MARK: waits while fifo_full. When !fifo_full, it writes the line marker with new_line_FIFO_done=1 in the same cycle, increments line_cnt, zeroes the sample index, then goes to HOLD.
- FSM state FRAME_MARK: same as LINE_MARK, but writes the frame marker with new_frame_FIFO_done=1, increments frame_cnt, and zeroes line_cnt and the sample index.
- FSM state HOLD: exactly one cycle; new_line/new_frame are ignored, then back to IDLE. This covers the cycle in which the upstream flag is still high after done, preventing a double marker.
- Latency: request flag high at IDLE edge k. Marker write and done are asserted in the cycle after edge k+1. Total is 2 cycles from flag to write.
- Both flags high together: frame marker first. The line request is then serviced on the next IDLE pass, so its line marker carries line_cnt=1 of the new frame.
- Samples arriving when not writable are captured into hold if hold is empty. "Not writable" means any of: state not IDLE, fifo_full, a marker pending, or hold occupied.
- If hold is full and another sample arrives, the new sample is dropped and drop_cnt increments, saturating at 0xFFFF.
- Sample index increments per data word written and saturates at 2^IDX_W-1. line_cnt wraps mod 2^CNT_W, and frame_cnt wraps mod 2^30.
- A sample_valid coinciding with hold drain in the same cycle goes into hold, which is freed in that cycle. It is not dropped.

Test Plan:
- Reset release with no stimulus -> all outputs 0, no fifo_wr_en for 100 cycles.
- new_line held until done, fifo_full=0 -> exactly one write of 0x4000_0001 two cycles after the rise, with new_line_FIFO_done high that same single cycle. A second new_line gives 0x4000_0002.
- 15 line requests then new_frame -> line markers 1..15, then frame marker 0x8000_0001. line_cnt=0 and frame_cnt=1 after; the next line marker is 0x4001_0001.
- Samples 0x1234, 0x5678 on consecutive cycles after a line marker -> words 0x0000_1234, 0x0001_5678.
- A sample_valid arriving during LINE_MARK/HOLD is held, then written in IDLE with index 0.
- fifo_full=1 for 10 cycles with new_line and 3 samples -> no writes, no done. One sample is held and 2 are dropped (drop_cnt=2). After full clears: the held data word is written, then the line marker with done.
- new_line and new_frame rising together -> frame marker plus new_frame_FIFO_done, then HOLD, then line marker 0x4001_0001 plus new_line_FIFO_done.
- rst_n low while in LINE_MARK with fifo_full=1 -> immediate all-zero outputs. After release, with new_line still high, a single marker 0x4000_0001 is written.

Source files
------------

// File: rtl/mems_marker_fifo_writer.sv
// Merges MEMS line/frame marker requests and the sample stream into tagged 32-bit FIFO words.
// Each request flag gets a one-cycle done pulse. A 1-deep hold register absorbs samples that cannot be written in their own cycle.
module mems_marker_fifo_writer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned IDX_W  = 14,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              new_line,
    input  logic              new_frame,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              fifo_full,
    output logic              fifo_wr_en,
    output logic [31:0]       fifo_din,
    output logic              new_line_FIFO_done,
    output logic              new_frame_FIFO_done,
    output logic [CNT_W-1:0]  line_cnt,
    output logic [29:0]       frame_cnt,
    output logic [15:0]       drop_cnt
);

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned FRAME_W = 30;
    localparam int unsigned DROP_W  = 16;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LINE_MARK  = 2'd1,
        FRAME_MARK = 2'd2,
        HOLD       = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_hold_vld;
    logic [DATA_W-1:0]   r_hold_data;
    logic [IDX_W-1:0]    r_idx;

    logic                w_wr;
    logic [WORD_W-1:0]   w_din;
    logic                w_line_done;
    logic                w_frame_done;
    logic                w_drain;
    logic                w_direct;
    logic                w_capture;
    logic                w_drop;
    logic [CNT_W-1:0]    w_line_inc;
    logic [FRAME_W-1:0]  w_frame_inc;

    assign w_line_inc  = line_cnt + CNT_W'(1);
    assign w_frame_inc = frame_cnt + FRAME_W'(1);

    // Next state and this cycle's write selection
    always_comb begin
        w_state_nxt  = r_state;
        w_wr         = 1'b0;
        w_din        = '0;
        w_line_done  = 1'b0;
        w_frame_done = 1'b0;
        w_drain      = 1'b0;
        w_direct     = 1'b0;
        case (r_state)
            IDLE: begin
                if (!fifo_full) begin
                    if (r_hold_vld) begin
                        w_wr    = 1'b1;
                        w_drain = 1'b1;
                        w_din   = WORD_W'({2'b00, r_idx, r_hold_data});
                    end else if (new_frame) begin
                        w_state_nxt = FRAME_MARK;
                    end else if (new_line) begin
                        w_state_nxt = LINE_MARK;
                    end else if (sample_valid) begin
                        w_wr     = 1'b1;
                        w_direct = 1'b1;
                        w_din    = WORD_W'({2'b00, r_idx, sample_data});
                    end
                end
            end
            LINE_MARK: begin
                if (!fifo_full) begin
                    w_wr        = 1'b1;
                    w_line_done = 1'b1;
                    w_din       = {2'b01, 14'(frame_cnt), 16'(w_line_inc)};
                    w_state_nxt = HOLD;
                end
            end
            FRAME_MARK: begin
                if (!fifo_full) begin
                    w_wr         = 1'b1;
                    w_frame_done = 1'b1;
                    w_din        = {2'b10, w_frame_inc};
                    w_state_nxt  = HOLD;
                end
            end
            HOLD: begin
                // Upstream flag may still be high this cycle; ignore it
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // A sample not written directly lands in hold if it is empty or draining now
    assign w_capture = sample_valid && !w_direct && (!r_hold_vld || w_drain);
    assign w_drop    = sample_valid && !w_direct && !w_capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_vld          <= 1'b0;
            r_hold_data         <= '0;
            r_idx               <= '0;
            fifo_wr_en          <= 1'b0;
            fifo_din            <= '0;
            new_line_FIFO_done  <= 1'b0;
            new_frame_FIFO_done <= 1'b0;
            line_cnt            <= '0;
            frame_cnt           <= '0;
            drop_cnt            <= '0;
        end else begin
            fifo_wr_en          <= w_wr;
            new_line_FIFO_done  <= w_line_done;
            new_frame_FIFO_done <= w_frame_done;
            if (w_wr) begin
                fifo_din <= w_din;
            end

            if (w_capture) begin
                r_hold_vld  <= 1'b1;
                r_hold_data <= sample_data;
            end else if (w_drain) begin
                r_hold_vld  <= 1'b0;
            end

            if (w_drop && (drop_cnt != {DROP_W{1'b1}})) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end

            if (w_frame_done) begin
                frame_cnt <= w_frame_inc;
                line_cnt  <= '0;
                r_idx     <= '0;
            end else if (w_line_done) begin
                line_cnt  <= w_line_inc;
                r_idx     <= '0;
            end else if ((w_drain || w_direct) && (r_idx != {IDX_W{1'b1}})) begin
                r_idx     <= r_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mems_marker_fifo_writer.sv
// Scoreboard bench for mems_marker_fifo_writer: expected words are queued as stimulus is driven
// and compared as the DUT writes them.
module tb_mems_marker_fifo_writer;

    logic        clk;
    logic        rst_n;
    logic        new_line;
    logic        new_frame;
    logic        sample_valid;
    logic [15:0] sample_data;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [31:0] fifo_din;
    logic        new_line_FIFO_done;
    logic        new_frame_FIFO_done;
    logic [15:0] line_cnt;
    logic [29:0] frame_cnt;
    logic [15:0] drop_cnt;

    mems_marker_fifo_writer dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .new_line            (new_line),
        .new_frame           (new_frame),
        .sample_valid        (sample_valid),
        .sample_data         (sample_data),
        .fifo_full           (fifo_full),
        .fifo_wr_en          (fifo_wr_en),
        .fifo_din            (fifo_din),
        .new_line_FIFO_done  (new_line_FIFO_done),
        .new_frame_FIFO_done (new_frame_FIFO_done),
        .line_cnt            (line_cnt),
        .frame_cnt           (frame_cnt),
        .drop_cnt            (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] word;
        logic        ld;
        logic        fd;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [15:0] m_line  = '0;
    logic [29:0] m_frame = '0;
    logic [13:0] m_idx   = '0;
    logic        full_q  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=0x%08h exp=0x%08h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void push_line();
        exp_t e;
        m_line = m_line + 16'd1;
        m_idx  = '0;
        e.word = {2'b01, m_frame[13:0], m_line};
        e.ld   = 1'b1;
        e.fd   = 1'b0;
        exp_q.push_back(e);
    endfunction

    function automatic void push_frame();
        exp_t e;
        m_frame = m_frame + 30'd1;
        m_line  = '0;
        m_idx   = '0;
        e.word  = {2'b10, m_frame};
        e.ld    = 1'b0;
        e.fd    = 1'b0;
        e.fd    = 1'b1;
        exp_q.push_back(e);
    endfunction

    function automatic void push_data(input logic [15:0] d);
        exp_t e;
        e.word = {2'b00, m_idx, d};
        e.ld   = 1'b0;
        e.fd   = 1'b0;
        exp_q.push_back(e);
        if (m_idx != 14'h3FFF) m_idx = m_idx + 14'd1;
    endfunction

    // Bench plays the upstream: drop the flag once its done pulse is seen
    task automatic wait_line(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!new_line_FIFO_done && cyc < 20);
        check_eq("line_done_seen", 32'(new_line_FIFO_done), 32'd1);
        new_line = 1'b0;
    endtask

    task automatic wait_frame(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!new_frame_FIFO_done && cyc < 20);
        check_eq("frame_done_seen", 32'(new_frame_FIFO_done), 32'd1);
        new_frame = 1'b0;
    endtask

    task automatic do_line(output int cyc);
        @(negedge clk);
        new_line = 1'b1;
        push_line();
        wait_line(cyc);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_wr"},    32'(fifo_wr_en), 32'd0);
        check_eq({tag, "_din"},   fifo_din, 32'd0);
        check_eq({tag, "_done"},  32'({new_line_FIFO_done, new_frame_FIFO_done}), 32'd0);
        check_eq({tag, "_line"},  32'(line_cnt), 32'd0);
        check_eq({tag, "_frame"}, 32'(frame_cnt), 32'd0);
        check_eq({tag, "_drop"},  32'(drop_cnt), 32'd0);
    endtask

    always @(posedge clk) full_q <= fifo_full;

    // Output monitor: every write must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (fifo_wr_en) begin
            check_eq("wr_while_full", 32'(full_q), 32'd0);
            if (exp_q.size() == 0) begin
                check_eq("unexpected_wr", 32'(fifo_wr_en), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("word", fifo_din, e.word);
                check_eq("dones", 32'({new_line_FIFO_done, new_frame_FIFO_done}), 32'({e.ld, e.fd}));
            end
        end else if (new_line_FIFO_done || new_frame_FIFO_done) begin
            check_eq("done_without_wr", 32'({new_line_FIFO_done, new_frame_FIFO_done}), 32'd0);
        end
    end

    initial begin
        int cyc;
        rst_n        = 1'b0;
        new_line     = 1'b0;
        new_frame    = 1'b0;
        sample_valid = 1'b0;
        sample_data  = '0;
        fifo_full    = 1'b0;

        // Reset state, then 100 quiet cycles
        repeat (3) @(negedge clk);
        check_zero_outputs("rst");
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check_zero_outputs("idle");

        // Single line markers and flag-to-write latency
        do_line(cyc);
        check_eq("line_latency", 32'(cyc), 32'd2);
        do_line(cyc);
        check_eq("line_cnt_2", 32'(line_cnt), 32'd2);
        for (int i = 0; i < 13; i++) do_line(cyc);
        check_eq("line_cnt_15", 32'(line_cnt), 32'd15);

        // Frame marker resets line count
        @(negedge clk);
        new_frame = 1'b1;
        push_frame();
        wait_frame(cyc);
        repeat (2) @(negedge clk);
        check_eq("line_cnt_after_frame", 32'(line_cnt), 32'd0);
        check_eq("frame_cnt_1", 32'(frame_cnt), 32'd1);
        do_line(cyc);

        // Back-to-back direct samples
        sample_valid = 1'b1;
        sample_data  = 16'h1234;
        push_data(16'h1234);
        @(negedge clk);
        sample_data  = 16'h5678;
        push_data(16'h5678);
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Sample arriving while the line marker is in flight goes via hold
        new_line = 1'b1;
        push_line();
        push_data(16'hABCD);
        @(negedge clk);
        sample_valid = 1'b1;
        sample_data  = 16'hABCD;
        @(negedge clk);
        sample_valid = 1'b0;
        cyc = 1;
        if (!new_line_FIFO_done) wait_line(cyc);
        else new_line = 1'b0;
        repeat (5) @(negedge clk);

        // FIFO full: nothing written, one sample held, two dropped
        fifo_full = 1'b1;
        new_line  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sample_valid = (i < 3);
            sample_data  = 16'hC000 + 16'(i);
            @(negedge clk);
        end
        sample_valid = 1'b0;
        check_eq("drop_cnt_2", 32'(drop_cnt), 32'd2);
        check_eq("no_done_while_full", 32'(new_line_FIFO_done), 32'd0);
        push_data(16'hC000);
        push_line();
        fifo_full = 1'b0;
        wait_line(cyc);
        repeat (3) @(negedge clk);

        // Both flags together: frame first, then line on the next IDLE pass
        new_line  = 1'b1;
        new_frame = 1'b1;
        push_frame();
        push_line();
        wait_frame(cyc);
        wait_line(cyc);
        repeat (3) @(negedge clk);
        check_eq("frame_cnt_2", 32'(frame_cnt), 32'(m_frame));
        check_eq("line_cnt_1", 32'(line_cnt), 32'(m_line));
        check_eq("queue_empty_pre_rst", 32'(exp_q.size()), 32'd0);

        // Reset while stalled in LINE_MARK abandons the marker
        new_line = 1'b1;
        @(negedge clk);
        fifo_full = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midrst");
        @(negedge clk);
        fifo_full = 1'b0;
        repeat (2) @(negedge clk);
        m_line  = '0;
        m_frame = '0;
        m_idx   = '0;
        push_line();
        rst_n = 1'b1;
        wait_line(cyc);
        check_eq("post_rst_latency", 32'(cyc), 32'd2);
        repeat (5) @(negedge clk);
        check_eq("line_cnt_post_rst", 32'(line_cnt), 32'd1);
        check_eq("queue_empty_end", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
